// File: rtl/spi_master_gen_if.sv
// Bundles the transfer handshake and SPI pin signals of spi_master_gen.
interface spi_master_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 1,
  parameter int unsigned CS_W   = 3
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] ssel_n;

  // Side of the SPI master block itself
  modport master (
    input  start, tx_data, cs_sel, cpol, cpha, miso,
    output busy, done, rx_data, sclk, mosi, ssel_n
  );

  // Side of the controller issuing transfers and the attached SPI device
  modport slave (
    output start, tx_data, cs_sel, cpol, cpha, miso,
    input  busy, done, rx_data, sclk, mosi, ssel_n
  );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master: configurable width, SCLK divider,
// chip-select count and per-transfer CPOL/CPHA, with start/busy/done handshake.
module spi_master_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CS  = 1,
  parameter int unsigned CS_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_gen_if.master  bus
);

  localparam int unsigned TICK_W    = $clog2(CLK_DIV);
  localparam int unsigned NUM_EDGES = 2 * DATA_W;
  localparam int unsigned EDGE_W    = $clog2(NUM_EDGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                miso_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   ssel_n_q, ssel_n_d;

  logic                tick_last;
  logic                edge_go;
  logic                edge_lead;
  logic                edge_last;
  logic [NUM_CS-1:0]   sel_dec;

  assign tick_last = (tick_q == TICK_W'(CLK_DIV - 1));
  assign edge_lead = ~edge_q[0];
  assign edge_last = (edge_q == EDGE_W'(NUM_EDGES - 1));

  // Active-low one-hot select; out-of-range indices select nothing
  always_comb begin
    sel_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      sel_dec[i] = (bus.cs_sel != CS_W'(i));
    end
  end

  // Next-state, shift-register and registered-output logic
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ssel_n_d  = ssel_n_q;
    edge_go   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d   = '0;
        busy_d   = 1'b0;
        sclk_d   = cpol_q;
        mosi_d   = 1'b0;
        ssel_n_d = '1;
        if (bus.start) begin
          state_d  = S_SETUP;
          busy_d   = 1'b1;
          cpol_d   = bus.cpol;
          cpha_d   = bus.cpha;
          sclk_d   = bus.cpol;
          edge_d   = '0;
          ssel_n_d = sel_dec;
          // With cpha=0 the MSB is presented before the first edge
          if (bus.cpha) begin
            mosi_d  = 1'b0;
            tx_sh_d = bus.tx_data;
          end else begin
            mosi_d  = bus.tx_data[DATA_W-1];
            tx_sh_d = {bus.tx_data[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_SETUP: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          state_d = S_XFER;
          tick_d  = '0;
          edge_go = 1'b1;
        end
      end
      S_XFER: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          tick_d = '0;
          if (edge_q == EDGE_W'(NUM_EDGES)) begin
            state_d = S_HOLD;
          end else begin
            edge_go = 1'b1;
          end
        end
      end
      S_HOLD: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          state_d   = S_IDLE;
          tick_d    = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          sclk_d    = cpol_q;
          mosi_d    = 1'b0;
          ssel_n_d  = '1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One SCLK edge: sample on the phase-selected edge, shift out on the other
    if (edge_go) begin
      edge_d = edge_q + EDGE_W'(1);
      sclk_d = ~sclk_q;
      if (edge_lead != cpha_q) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_q};
      end else if (!edge_last) begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ssel_n_q  <= '1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      miso_q    <= bus.miso;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ssel_n_q  <= ssel_n_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ssel_n  = ssel_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: an 8-bit/4-CS instance and a 16-bit instance.
module tb_spi_master_gen;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_master_gen_if #(.DATA_W(8),  .NUM_CS(4), .CS_W(3)) b8 ();
  spi_master_gen_if #(.DATA_W(16), .NUM_CS(1), .CS_W(3)) b16 ();

  spi_master_gen #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .CS_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .bus(b8.master));
  spi_master_gen #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(1), .CS_W(3)) u_dut16 (
    .clk(clk), .rst(rst), .bus(b16.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations collected while watching one 8-bit transfer
  int         busy_len, sel_cyc, rises, falls, mosi_bad, done_total;
  logic [3:0] sel_seen;
  logic [7:0] mosi_cap, end_rx;
  logic       end_done, end_sclk, setup_sclk;
  bit         timed_out;

  // Present a request on the 8-bit bus for exactly one accepting edge
  task automatic start8(input logic [7:0] tx, input logic [2:0] cs, input logic cp, input logic ch);
    @(negedge clk);
    b8.tx_data = tx; b8.cs_sel = cs; b8.cpol = cp; b8.cpha = ch; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  // Follow a transfer until busy drops; mode 0 loops miso to mosi, mode 1 is a
  // slave shifting sw out on each falling sclk
  task automatic watch8(input int mode, input logic [7:0] sw, input bit junk,
                        input bit chain, input logic [7:0] chain_tx, input int abort_at);
    logic [7:0] slv;
    logic       psclk, pmosi;
    slv = sw; busy_len = 0; sel_cyc = 0; sel_seen = '0; rises = 0; falls = 0;
    mosi_cap = '0; mosi_bad = 0; timed_out = 1'b1; end_done = 1'b0;
    setup_sclk = b8.sclk; psclk = b8.sclk; pmosi = b8.mosi;
    for (int c = 0; c < 1000; c++) begin
      if (b8.done) done_total++;
      if (!b8.busy) begin
        timed_out = 1'b0; end_rx = b8.rx_data; end_done = b8.done; end_sclk = b8.sclk;
        if (chain) begin
          b8.tx_data = chain_tx; b8.cpol = 1'b0; b8.cpha = 1'b0; b8.cs_sel = 3'd0; b8.start = 1'b1;
        end
        break;
      end
      busy_len++;
      if (b8.ssel_n != 4'hF) sel_cyc++;
      sel_seen = sel_seen | ~b8.ssel_n;
      if (c > 0) begin
        if (!psclk && b8.sclk) begin rises++; mosi_cap = {mosi_cap[6:0], b8.mosi}; end
        if (psclk && !b8.sclk) begin
          falls++;
          if (mode == 1) begin b8.miso = slv[7]; slv = {slv[6:0], 1'b0}; end
        end
        if (b8.mosi !== pmosi && !(psclk && !b8.sclk)) mosi_bad++;
      end
      if (mode == 0) b8.miso = b8.mosi;
      psclk = b8.sclk; pmosi = b8.mosi;
      if (junk && (busy_len == 10 || busy_len == 40)) begin
        b8.start = 1'b1; b8.tx_data = 8'hFF; b8.cpol = 1'b1; b8.cpha = 1'b1; b8.cs_sel = 3'd1;
      end else begin
        b8.start = 1'b0;
      end
      if (abort_at != 0 && busy_len == abort_at) begin
        rst = 1'b1; timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.start = 0; b8.tx_data = '0; b8.cs_sel = '0; b8.cpol = 0; b8.cpha = 0; b8.miso = 0;
    b16.start = 0; b16.tx_data = '0; b16.cs_sel = '0; b16.cpol = 0; b16.cpha = 0; b16.miso = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b8.busy); end
    n_checks++; if (b8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", b8.done); end
    n_checks++; if (b8.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h want 00", b8.rx_data); end
    n_checks++; if (b8.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", b8.sclk); end
    n_checks++; if (b8.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", b8.mosi); end
    n_checks++; if (b8.ssel_n !== 4'hF) begin n_fail++; $display("FAIL reset_ssel: got %b want 1111", b8.ssel_n); end
    n_checks++; if (b16.ssel_n !== 1'b1) begin n_fail++; $display("FAIL reset_ssel16: got %b want 1", b16.ssel_n); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", b8.busy); end
  endtask

  task automatic test_mode0();
    start8(8'hA5, 3'd0, 1'b0, 1'b0);
    watch8(0, 8'h00, 0, 0, 8'h00, 0);
    n_checks++; if (timed_out || busy_len != 72) begin n_fail++; $display("FAIL m0_busy_len: got %0d want 72", busy_len); end
    n_checks++; if (sel_cyc != 72) begin n_fail++; $display("FAIL m0_ssel_cycles: got %0d want 72", sel_cyc); end
    n_checks++; if (sel_seen !== 4'b0001) begin n_fail++; $display("FAIL m0_ssel_which: got %b want 0001", sel_seen); end
    n_checks++; if (rises != 8 || falls != 8) begin n_fail++; $display("FAIL m0_edges: got %0d/%0d want 8/8", rises, falls); end
    n_checks++; if (end_done !== 1'b1) begin n_fail++; $display("FAIL m0_done: got %b want 1", end_done); end
    n_checks++; if (end_rx !== 8'hA5) begin n_fail++; $display("FAIL m0_rx: got %h want a5", end_rx); end
    n_checks++; if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi_bits: got %h want a5", mosi_cap); end
    n_checks++; if (mosi_bad != 0) begin n_fail++; $display("FAIL m0_mosi_timing: got %0d want 0", mosi_bad); end
    @(negedge clk);
    n_checks++; if (b8.done !== 1'b0) begin n_fail++; $display("FAIL m0_done_pulse: got %b want 0", b8.done); end
    n_checks++; if (b8.rx_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_hold: got %h want a5", b8.rx_data); end
  endtask

  task automatic test_mode3();
    start8(8'h3C, 3'd0, 1'b1, 1'b1);
    watch8(1, 8'hC3, 0, 0, 8'h00, 0);
    n_checks++; if (setup_sclk !== 1'b1) begin n_fail++; $display("FAIL m3_setup_sclk: got %b want 1", setup_sclk); end
    n_checks++; if (timed_out || busy_len != 72) begin n_fail++; $display("FAIL m3_busy_len: got %0d want 72", busy_len); end
    n_checks++; if (end_rx !== 8'hC3) begin n_fail++; $display("FAIL m3_rx: got %h want c3", end_rx); end
    n_checks++; if (mosi_cap !== 8'h3C) begin n_fail++; $display("FAIL m3_mosi_bits: got %h want 3c", mosi_cap); end
    n_checks++; if (mosi_bad != 0) begin n_fail++; $display("FAIL m3_mosi_timing: got %0d want 0", mosi_bad); end
    n_checks++; if (falls != 8) begin n_fail++; $display("FAIL m3_falls: got %0d want 8", falls); end
    n_checks++; if (end_done !== 1'b1 || end_sclk !== 1'b1) begin n_fail++; $display("FAIL m3_done_sclk: got %b%b want 11", end_done, end_sclk); end
    @(negedge clk);
    n_checks++; if (b8.sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b want 1", b8.sclk); end
  endtask

  task automatic test_cs_select();
    start8(8'h5A, 3'd2, 1'b0, 1'b0);
    watch8(0, 8'h00, 0, 0, 8'h00, 0);
    n_checks++; if (sel_seen !== 4'b0100 || sel_cyc != 72) begin n_fail++; $display("FAIL cs2_select: got %b/%0d want 0100/72", sel_seen, sel_cyc); end
    n_checks++; if (end_done !== 1'b1 || end_rx !== 8'h5A) begin n_fail++; $display("FAIL cs2_done_rx: got %b/%h want 1/5a", end_done, end_rx); end
    start8(8'hC6, 3'd5, 1'b0, 1'b0);
    watch8(0, 8'h00, 0, 0, 8'h00, 0);
    n_checks++; if (sel_seen !== 4'b0000 || sel_cyc != 0) begin n_fail++; $display("FAIL cs5_none: got %b/%0d want 0000/0", sel_seen, sel_cyc); end
    n_checks++; if (timed_out || busy_len != 72) begin n_fail++; $display("FAIL cs5_busy_len: got %0d want 72", busy_len); end
    n_checks++; if (end_done !== 1'b1 || end_rx !== 8'hC6) begin n_fail++; $display("FAIL cs5_done_rx: got %b/%h want 1/c6", end_done, end_rx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first_rx;
    int         first_len;
    logic [3:0] first_sel;
    done_total = 0;
    start8(8'h11, 3'd0, 1'b0, 1'b0);
    watch8(0, 8'h00, 1, 1, 8'h22, 0);
    first_rx = end_rx; first_len = busy_len; first_sel = sel_seen;
    n_checks++; if (timed_out || first_len != 72) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 72", first_len); end
    n_checks++; if (first_rx !== 8'h11 || first_sel !== 4'b0001) begin n_fail++; $display("FAIL b2b_first_rx_sel: got %h/%b want 11/0001", first_rx, first_sel); end
    @(negedge clk);
    b8.start = 1'b0;
    n_checks++; if (b8.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", b8.busy); end
    watch8(0, 8'h00, 0, 0, 8'h00, 0);
    n_checks++; if (timed_out || busy_len != 72) begin n_fail++; $display("FAIL b2b_second_len: got %0d want 72", busy_len); end
    n_checks++; if (end_rx !== 8'h22) begin n_fail++; $display("FAIL b2b_second_rx: got %h want 22", end_rx); end
    repeat (20) begin
      @(negedge clk);
      if (b8.done) done_total++;
    end
    n_checks++; if (done_total != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_total); end
  endtask

  task automatic test_reset_abort();
    start8(8'h5A, 3'd0, 1'b1, 1'b1);
    watch8(1, 8'hFF, 0, 0, 8'h00, 30);
    n_checks++; if (busy_len != 30) begin n_fail++; $display("FAIL abort_reached: got %0d want 30", busy_len); end
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin n_fail++; $display("FAIL abort_busy_done: got %b%b want 00", b8.busy, b8.done); end
    n_checks++; if (b8.ssel_n !== 4'hF || b8.sclk !== 1'b0) begin n_fail++; $display("FAIL abort_pins: got %b/%b want 1111/0", b8.ssel_n, b8.sclk); end
    n_checks++; if (b8.rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_rx: got %h want 00", b8.rx_data); end
    done_total = 0;
    repeat (100) begin
      @(negedge clk);
      if (b8.done || b8.busy) done_total++;
    end
    n_checks++; if (done_total != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d want 0", done_total); end
    start8(8'h96, 3'd0, 1'b0, 1'b0);
    watch8(0, 8'h00, 0, 0, 8'h00, 0);
    n_checks++; if (timed_out || busy_len != 72 || end_rx !== 8'h96) begin n_fail++; $display("FAIL abort_after: got %0d/%h want 72/96", busy_len, end_rx); end
  endtask

  task automatic test_wide();
    int          len;
    logic [15:0] cap;
    logic        psclk, dn;
    bit          to;
    len = 0; cap = '0; to = 1'b1; dn = 1'b0;
    @(negedge clk);
    b16.tx_data = 16'h8001; b16.cs_sel = 3'd0; b16.cpol = 0; b16.cpha = 0; b16.miso = 1'b1; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    psclk = b16.sclk;
    for (int c = 0; c < 1000; c++) begin
      if (!b16.busy) begin to = 1'b0; dn = b16.done; break; end
      len++;
      if (!psclk && b16.sclk) cap = {cap[14:0], b16.mosi};
      psclk = b16.sclk;
      @(negedge clk);
    end
    n_checks++; if (to || len != 68) begin n_fail++; $display("FAIL wide_busy_len: got %0d want 68", len); end
    n_checks++; if (b16.rx_data !== 16'hFFFF || dn !== 1'b1) begin n_fail++; $display("FAIL wide_rx_done: got %h/%b want ffff/1", b16.rx_data, dn); end
    n_checks++; if (cap !== 16'h8001) begin n_fail++; $display("FAIL wide_mosi_bits: got %h want 8001", cap); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_cs_select();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
